// File: rtl/aes_pkg.sv
// Shared AES byte-level maps: GF(2^8) arithmetic and the S-box affine maps.
// Key expansion, round logic and the SubBytes engine all use these functions,
// so they share one definition of the field and the affine transforms.
//   AES_AFFINE_C : additive constant of the forward affine map (0x63)
//   GF_POLY      : field modulus x^8+x^4+x^3+x+1
//   gf_mul8      : GF(2^8) multiply
//   gf_inv8      : GF(2^8) multiplicative inverse, inv(0) = 0
//   aff_fwd8     : linear part A of the forward affine map
//   aff_inv8     : linear part Ainv, the inverse of A
package aes_pkg;

    localparam logic [7:0] AES_AFFINE_C = 8'h63;
    localparam logic [8:0] GF_POLY      = 9'h11B;

    // Shift-and-add multiply, reducing by the modulus whenever bit 7 falls out.
    function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = sh[7] ? ({sh[6:0], 1'b0} ^ GF_POLY[7:0]) : {sh[6:0], 1'b0};
        end
        return acc;
    endfunction

    // x^-1 = x^254 in GF(2^8); this addition chain also maps 0 to 0.
    function automatic logic [7:0] gf_inv8(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, t;
        x2  = gf_mul8(x, x);
        x3  = gf_mul8(x2, x);
        t   = gf_mul8(x3, x3);          // x^6
        x12 = gf_mul8(t, t);
        x15 = gf_mul8(x12, x3);
        t   = gf_mul8(x15, x15);        // x^30
        t   = gf_mul8(t, t);            // x^60
        t   = gf_mul8(t, t);            // x^120
        t   = gf_mul8(t, t);            // x^240
        t   = gf_mul8(t, x12);          // x^252
        return gf_mul8(t, x2);          // x^254
    endfunction

    // A(b) = b ^ rotl(b,1) ^ rotl(b,2) ^ rotl(b,3) ^ rotl(b,4)
    function automatic logic [7:0] aff_fwd8(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]};
    endfunction

    // Ainv(b) = rotl(b,1) ^ rotl(b,3) ^ rotl(b,6)
    function automatic logic [7:0] aff_inv8(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]};
    endfunction

endpackage

// File: rtl/aes_sbox_dual.sv
// One-byte forward/inverse AES S-box, purely combinational, split at the
// GF inverse so a register can be placed between the two halves.
//   x_i       : input byte
//   inv_i     : 0 = forward S-box, 1 = inverse S-box (front half)
//   mid_o     : gf_inv8(pre-map(x_i)), pre-map = Ainv(x^0x63) if inverse, else x
//   mid_i     : mid-point value fed to the back half (mid_o or a registered copy)
//   mid_inv_i : mode bit belonging to mid_i
//   y_o       : back half: A(mid_i)^0x63 if forward, else mid_i unchanged
module aes_sbox_dual
    import aes_pkg::*;
(
    input  logic [7:0] x_i,
    input  logic       inv_i,
    output logic [7:0] mid_o,
    input  logic [7:0] mid_i,
    input  logic       mid_inv_i,
    output logic [7:0] y_o
);

    logic [7:0] pre;

    assign pre   = inv_i ? aff_inv8(x_i ^ AES_AFFINE_C) : x_i;
    assign mid_o = gf_inv8(pre);
    assign y_o   = mid_inv_i ? mid_i : (aff_fwd8(mid_i) ^ AES_AFFINE_C);

endmodule

// File: rtl/aes_sub_bytes_pipe.sv
// Pipelined SubBytes / InvSubBytes engine over NUM_BYTES bytes, with a
// per-word mode bit and valid/ready handshakes carrying full backpressure.
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready is combinational)
//   in_inv, in_data     : mode bit and bytes of the input word (byte i = [8i+7:8i])
//   out_valid/out_ready : output handshake
//   out_inv, out_data   : mode bit and substituted bytes of the output word
//   busy                : some pipeline stage holds a valid word
// PIPE_STAGES = 1 registers the complete byte function; PIPE_STAGES = 2
// registers the GF-inverse mid-point first and the post-map second.
module aes_sub_bytes_pipe
    import aes_pkg::*;
#(
    parameter int NUM_BYTES   = 4,
    parameter int PIPE_STAGES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_inv,
    input  logic [8*NUM_BYTES-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_inv,
    output logic [8*NUM_BYTES-1:0] out_data,
    output logic                   busy
);

    localparam int W = 8 * NUM_BYTES;

    if (NUM_BYTES < 1 || NUM_BYTES > 16) begin : g_bad_bytes
        $error("aes_sub_bytes_pipe: NUM_BYTES must be 1..16");
    end
    if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_stages
        $error("aes_sub_bytes_pipe: PIPE_STAGES must be 1 or 2");
    end

    logic [W-1:0] mid_c;
    logic [W-1:0] post_in;
    logic         post_inv;
    logic [W-1:0] y_c;

    for (genvar b = 0; b < NUM_BYTES; b++) begin : g_byte
        aes_sbox_dual u_sbox (
            .x_i       (in_data[8*b +: 8]),
            .inv_i     (in_inv),
            .mid_o     (mid_c[8*b +: 8]),
            .mid_i     (post_in[8*b +: 8]),
            .mid_inv_i (post_inv),
            .y_o       (y_c[8*b +: 8])
        );
    end

    if (PIPE_STAGES == 1) begin : g_one
        logic         vld_p0_q, vld_p0_d;
        logic         inv_p0_q;
        logic [W-1:0] data_p0_q;
        logic         rdy_p0;

        // Both halves of the S-box feed the single register directly.
        assign post_in  = mid_c;
        assign post_inv = in_inv;

        assign rdy_p0   = !vld_p0_q || out_ready;
        assign vld_p0_d = rdy_p0 ? in_valid : vld_p0_q;

        // Stage 0: full substitution
        always_ff @(posedge clk) begin
            if (rst) vld_p0_q <= 1'b0;
            else     vld_p0_q <= vld_p0_d;
        end

        always_ff @(posedge clk) begin
            if (rdy_p0 && in_valid) begin
                data_p0_q <= y_c;
                inv_p0_q  <= in_inv;
            end
        end

        assign in_ready  = rdy_p0;
        assign out_valid = vld_p0_q;
        assign out_inv   = inv_p0_q;
        assign out_data  = data_p0_q;
        assign busy      = vld_p0_q;
    end else begin : g_two
        logic         vld_p0_q, vld_p0_d;
        logic         vld_p1_q, vld_p1_d;
        logic         inv_p0_q, inv_p1_q;
        logic [W-1:0] mid_p0_q;
        logic [W-1:0] data_p1_q;
        logic         rdy_p0, rdy_p1;

        // The back half of the S-box works on the registered mid-point.
        assign post_in  = mid_p0_q;
        assign post_inv = inv_p0_q;

        // A stage can load when it is empty or its word is leaving this cycle.
        assign rdy_p1   = !vld_p1_q || out_ready;
        assign rdy_p0   = !vld_p0_q || rdy_p1;
        assign vld_p0_d = rdy_p0 ? in_valid : vld_p0_q;
        assign vld_p1_d = rdy_p1 ? vld_p0_q : vld_p1_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p0_q <= 1'b0;
                vld_p1_q <= 1'b0;
            end else begin
                vld_p0_q <= vld_p0_d;
                vld_p1_q <= vld_p1_d;
            end
        end

        // Stage 0: pre-map and GF inverse
        always_ff @(posedge clk) begin
            if (rdy_p0 && in_valid) begin
                mid_p0_q <= mid_c;
                inv_p0_q <= in_inv;
            end
        end

        // Stage 1: post-map
        always_ff @(posedge clk) begin
            if (rdy_p1 && vld_p0_q) begin
                data_p1_q <= y_c;
                inv_p1_q  <= inv_p0_q;
            end
        end

        assign in_ready  = rdy_p0;
        assign out_valid = vld_p1_q;
        assign out_inv   = inv_p1_q;
        assign out_data  = data_p1_q;
        assign busy      = vld_p0_q || vld_p1_q;
    end

endmodule

// File: tb/tb_aes_sub_bytes_pipe.sv
module tb_aes_sub_bytes_pipe;

    logic clk;
    logic rst;

    // Instance A: 4 bytes, 1 stage
    logic         a_in_valid, a_in_ready, a_in_inv;
    logic [31:0]  a_in_data;
    logic         a_out_valid, a_out_ready, a_out_inv, a_busy;
    logic [31:0]  a_out_data;

    // Instance B: 16 bytes, 2 stages
    logic         b_in_valid, b_in_ready, b_in_inv;
    logic [127:0] b_in_data;
    logic         b_out_valid, b_out_ready, b_out_inv, b_busy;
    logic [127:0] b_out_data;

    aes_sub_bytes_pipe #(.NUM_BYTES(4), .PIPE_STAGES(1)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_inv(a_out_inv), .out_data(a_out_data),
        .busy(a_busy)
    );

    aes_sub_bytes_pipe #(.NUM_BYTES(16), .PIPE_STAGES(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_inv(b_out_inv), .out_data(b_out_data),
        .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk  = 0;
    int npass = 0;
    int nfail = 0;

    // Reference S-box tables, built from the field definition by search.
    logic [7:0] sbox_ref  [256];
    logic [7:0] isbox_ref [256];

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_inv(input logic [7:0] x);
        if (x == 8'h00) return 8'h00;
        for (int y = 1; y < 256; y++) if (ref_mul(x, 8'(y)) == 8'h01) return 8'(y);
        return 8'h00;
    endfunction

    function automatic logic [7:0] ref_fwd(input logic [7:0] x);
        logic [7:0] v, r, c;
        v = ref_inv(x);
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            r[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8] ^ v[(i + 7) % 8] ^ c[i];
        return r;
    endfunction

    function automatic logic [127:0] ref_word(input logic [127:0] d, input logic inv, input int nb);
        logic [127:0] r;
        r = '0;
        for (int b = 0; b < nb; b++)
            r[8*b +: 8] = inv ? isbox_ref[d[8*b +: 8]] : sbox_ref[d[8*b +: 8]];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        nchk++;
        assert (obs === exp) begin
            npass++;
        end else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0]  fwd_mem [256];
    logic [31:0]  sw_in;
    logic [7:0]   v;
    logic [127:0] e;
    logic [127:0] w0, w1, w2;
    logic         i0, i1, i2;
    logic [128:0] sb [$];
    logic [128:0] exp_w;
    int           acc_n, cyc;

    initial begin
        for (int x = 0; x < 256; x++) sbox_ref[x] = ref_fwd(8'(x));
        for (int x = 0; x < 256; x++) isbox_ref[sbox_ref[x]] = 8'(x);

        rst = 1'b1;
        a_in_valid = 1'b0; a_in_inv = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_inv = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_in_ready", a_in_ready, 1);
        chk("rst_b_out_valid", b_out_valid, 0);
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_in_ready", b_in_ready, 1);

        // Known vectors on the single-stage engine
        a_in_valid = 1'b1; a_in_inv = 1'b0; a_in_data = 32'hFF53_0100;
        tick();
        chk("vec_fwd", {a_out_valid, a_out_inv, a_out_data}, {1'b1, 1'b0, 32'h16ED_7C63});
        chk("vec_fwd_busy", a_busy, 1);
        a_in_inv = 1'b1; a_in_data = 32'h16ED_7C63;
        tick();
        chk("vec_inv", {a_out_valid, a_out_inv, a_out_data}, {1'b1, 1'b1, 32'hFF53_0100});

        // Forward sweep: every value in every lane, streamed at full rate
        for (int i = 0; i <= 256; i++) begin
            if (i > 0) begin
                v = 8'(i - 1);
                sw_in = {v + 8'd3, v + 8'd2, v + 8'd1, v};
                e = ref_word({96'd0, sw_in}, 1'b0, 4);
                chk("sweep_fwd", {a_out_valid, a_out_inv, a_out_data}, {1'b1, 1'b0, e[31:0]});
                fwd_mem[i - 1] = a_out_data;
            end
            if (i < 256) begin
                v = 8'(i);
                a_in_valid = 1'b1; a_in_inv = 1'b0;
                a_in_data = {v + 8'd3, v + 8'd2, v + 8'd1, v};
            end else begin
                a_in_valid = 1'b0;
            end
            tick();
        end

        // Inverse sweep of the forward results must give back the originals
        for (int i = 0; i <= 256; i++) begin
            if (i > 0) begin
                v = 8'(i - 1);
                sw_in = {v + 8'd3, v + 8'd2, v + 8'd1, v};
                chk("sweep_identity", {a_out_valid, a_out_inv, a_out_data}, {1'b1, 1'b1, sw_in});
            end
            if (i < 256) begin
                a_in_valid = 1'b1; a_in_inv = 1'b1; a_in_data = fwd_mem[i];
            end else begin
                a_in_valid = 1'b0;
            end
            tick();
        end
        chk("sweep_idle", a_out_valid, 0);

        // Two-stage engine: alternating modes back to back
        for (int i = 0; i < 10; i++) begin
            if (i == 1) chk("p2_latency_not1", b_out_valid, 0);
            if (i >= 2) begin
                e = ((i - 2) % 2 == 1) ? 128'd0 : {16{8'h63}};
                chk("p2_alt", {b_out_valid, b_out_inv, b_out_data}, {1'b1, 1'((i - 2) % 2), e});
            end
            if (i < 8) begin
                b_in_valid = 1'b1;
                b_in_inv   = 1'(i % 2);
                b_in_data  = (i % 2 == 1) ? {16{8'h63}} : 128'd0;
            end else begin
                b_in_valid = 1'b0;
            end
            tick();
        end
        chk("p2_alt_idle", b_out_valid, 0);

        // Two-stage engine: fill with out_ready low, stall, then drain
        w0 = {$urandom, $urandom, $urandom, $urandom}; i0 = 1'($urandom_range(0, 1));
        w1 = {$urandom, $urandom, $urandom, $urandom}; i1 = 1'($urandom_range(0, 1));
        w2 = {$urandom, $urandom, $urandom, $urandom}; i2 = 1'($urandom_range(0, 1));
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_inv = i0; b_in_data = w0;
        tick();
        chk("fill_ready_after1", b_in_ready, 1);
        b_in_inv = i1; b_in_data = w1;
        tick();
        chk("fill_ready_after2", b_in_ready, 0);
        b_in_inv = i2; b_in_data = w2;
        for (int k = 0; k < 5; k++) begin
            chk("stall_in_ready", b_in_ready, 0);
            chk("stall_out", {b_out_valid, b_out_inv, b_out_data}, {1'b1, i0, ref_word(w0, i0, 16)});
            tick();
        end
        b_out_ready = 1'b1;
        #1;
        chk("release_in_ready", b_in_ready, 1);
        tick();
        b_in_valid = 1'b0;
        chk("drain_w1", {b_out_valid, b_out_inv, b_out_data}, {1'b1, i1, ref_word(w1, i1, 16)});
        tick();
        chk("drain_w2", {b_out_valid, b_out_inv, b_out_data}, {1'b1, i2, ref_word(w2, i2, 16)});
        tick();
        chk("drain_empty", {b_out_valid, b_busy}, 0);

        // Reset with two words in flight, in_valid held high during reset
        b_in_valid = 1'b1; b_in_inv = 1'b0; b_in_data = {$urandom, $urandom, $urandom, $urandom};
        a_in_valid = 1'b1; a_in_inv = 1'b1; a_in_data = $urandom;
        tick();
        b_in_data = {$urandom, $urandom, $urandom, $urandom};
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b_in_valid = 1'b0; a_in_valid = 1'b0;
        #1;
        chk("midrst_b", {b_out_valid, b_busy, b_in_ready}, {1'b0, 1'b0, 1'b1});
        chk("midrst_a", {a_out_valid, a_busy, a_in_ready}, {1'b0, 1'b0, 1'b1});
        b_in_valid = 1'b1; b_in_inv = 1'b0; b_in_data = '0;
        a_in_valid = 1'b1; a_in_inv = 1'b0; a_in_data = '0;
        tick();
        b_in_valid = 1'b0; a_in_valid = 1'b0;
        chk("postrst_a", {a_out_valid, a_out_inv, a_out_data}, {1'b1, 1'b0, 32'h6363_6363});
        chk("postrst_b_early", b_out_valid, 0);
        tick();
        chk("postrst_b", {b_out_valid, b_out_inv, b_out_data}, {1'b1, 1'b0, {16{8'h63}}});
        tick();

        // Random traffic with stalls on the 16-byte, two-stage engine
        acc_n = 0; cyc = 0; sb.delete();
        while ((acc_n < 10000 || sb.size() > 0) && cyc < 60000) begin
            b_in_valid  = (acc_n < 10000) && ($urandom_range(0, 9) < 7);
            b_in_inv    = 1'($urandom_range(0, 1));
            b_in_data   = {$urandom, $urandom, $urandom, $urandom};
            b_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (b_out_valid && b_out_ready) begin
                if (sb.size() == 0) begin
                    chk("rand16_spurious", b_out_valid, 0);
                end else begin
                    exp_w = sb.pop_front();
                    chk("rand16", {b_out_inv, b_out_data}, exp_w);
                end
            end
            if (b_in_valid && b_in_ready) begin
                sb.push_back({b_in_inv, ref_word(b_in_data, b_in_inv, 16)});
                acc_n++;
            end
            tick();
            cyc++;
        end
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        chk("rand16_drain", (acc_n >= 10000) && (sb.size() == 0), 1);

        // Random traffic with stalls on the 4-byte, single-stage engine
        acc_n = 0; cyc = 0; sb.delete();
        while ((acc_n < 2000 || sb.size() > 0) && cyc < 20000) begin
            a_in_valid  = (acc_n < 2000) && ($urandom_range(0, 9) < 7);
            a_in_inv    = 1'($urandom_range(0, 1));
            a_in_data   = $urandom;
            a_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (a_out_valid && a_out_ready) begin
                if (sb.size() == 0) begin
                    chk("rand4_spurious", a_out_valid, 0);
                end else begin
                    exp_w = sb.pop_front();
                    chk("rand4", {a_out_inv, a_out_data}, {exp_w[128], exp_w[31:0]});
                end
            end
            if (a_in_valid && a_in_ready) begin
                sb.push_back({a_in_inv, ref_word({96'd0, a_in_data}, a_in_inv, 4)});
                acc_n++;
            end
            tick();
            cyc++;
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        chk("rand4_drain", (acc_n >= 2000) && (sb.size() == 0), 1);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
